// File: rtl/ppu_fb_writer_if.sv
// Pixel stream from the Game Boy PPU into the framebuffer writer.
// A pixel transfers on a cycle where px_valid and px_ready are both high.
interface ppu_fb_writer_if;
  logic       px_valid;
  logic       px_ready;
  logic [1:0] px_color;
  logic       px_sof;

  // PPU side: offers pixels
  modport master (
    output px_valid,
    output px_color,
    output px_sof,
    input  px_ready
  );

  // Framebuffer writer side: accepts pixels
  modport slave (
    input  px_valid,
    input  px_color,
    input  px_sof,
    output px_ready
  );
endinterface

// File: rtl/ppu_fb_writer.sv
// Framebuffer writer: maps PPU colour indices through the DMG palette and
// writes 2-bit shades into port A of the 160x144 framebuffer. Blanks the
// whole framebuffer to shade 0 after reset and whenever the LCD turns off.
module ppu_fb_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  ppu_fb_writer_if.slave    px,
  input  logic [7:0]        palette,
  input  logic              lcd_on,
  output logic [ADDR_W-1:0] addra,
  output logic [1:0]        dina,
  output logic              wea,
  output logic              frame_done,
  output logic              sync_err,
  output logic              clearing
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_CLEAR    = 2'd0,
    S_OFF      = 2'd1,
    S_WAIT_SOF = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_reg, clr_next;
  logic [X_W-1:0]    x_reg, x_next;
  logic [Y_W-1:0]    y_reg, y_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] addra_reg, addra_next;
  logic [1:0]        dina_reg, dina_next;
  logic              wea_reg, wea_next;
  logic              frame_done_reg, frame_done_next;
  logic              sync_err_reg, sync_err_next;

  logic              accept;
  logic [1:0]        shade;
  logic [1:0]        shade_lut [4];

  // Palette lookup table: entry i is the shade for colour index i
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pal
      assign shade_lut[gi] = palette[2*gi+1 : 2*gi];
    end
  endgenerate

  // Ready is refused while clearing, and also in the very cycle lcd_on drops
  // so that no pixel is lost half-way into the switch to CLEAR.
  assign px.px_ready = (state_reg != S_CLEAR) && lcd_on;
  assign accept      = px.px_valid && px.px_ready;
  assign shade       = shade_lut[px.px_color];

  assign clearing   = (state_reg == S_CLEAR);
  assign addra      = addra_reg;
  assign dina       = dina_reg;
  assign wea        = wea_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

  // Next-state, position tracking and write-port decode
  always_comb begin
    state_next      = state_reg;
    clr_next        = clr_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    base_next       = base_reg;
    addra_next      = addra_reg;
    dina_next       = dina_reg;
    wea_next        = 1'b0;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;

    if (state_reg == S_CLEAR) begin
      // One blank write per cycle; lcd_on is only looked at once the sweep ends
      wea_next   = 1'b1;
      addra_next = clr_reg;
      dina_next  = 2'b00;
      if (clr_reg == LAST_ADDR) begin
        clr_next   = '0;
        state_next = lcd_on ? S_WAIT_SOF : S_OFF;
      end else begin
        clr_next = clr_reg + 1'b1;
      end
    end else if (!lcd_on) begin
      // LCD switched off beats everything else
      state_next = S_CLEAR;
      clr_next   = '0;
    end else begin
      case (state_reg)
        S_OFF: begin
          // Any pixel accepted here is simply dropped
          state_next = S_WAIT_SOF;
        end
        S_WAIT_SOF: begin
          if (accept && px.px_sof) begin
            wea_next   = 1'b1;
            addra_next = '0;
            dina_next  = shade;
            x_next     = X_W'(1);
            y_next     = '0;
            base_next  = '0;
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            wea_next  = 1'b1;
            dina_next = shade;
            if (px.px_sof) begin
              // Frame start arrived early: restart the frame from this pixel
              sync_err_next = 1'b1;
              addra_next    = '0;
              x_next        = X_W'(1);
              y_next        = '0;
              base_next     = '0;
            end else begin
              addra_next = base_reg + ADDR_W'(x_reg);
              if (x_reg != X_LAST) begin
                x_next = x_reg + 1'b1;
              end else begin
                x_next = '0;
                if (y_reg == Y_LAST) begin
                  frame_done_next = 1'b1;
                  y_next          = '0;
                  base_next       = '0;
                  state_next      = S_WAIT_SOF;
                end else begin
                  y_next    = y_reg + 1'b1;
                  base_next = base_reg + LINE_STEP;
                end
              end
            end
          end
        end
        default: begin
          state_next = S_CLEAR;
        end
      endcase
    end
  end

  // State and registered write-port outputs
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_reg      <= S_CLEAR;
      clr_reg        <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      base_reg       <= '0;
      addra_reg      <= '0;
      dina_reg       <= '0;
      wea_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_reg        <= clr_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      base_reg       <= base_next;
      addra_reg      <= addra_next;
      dina_reg       <= dina_next;
      wea_reg        <= wea_next;
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= sync_err_next;
    end
  end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: clear sweep, full frame, gaps/discards,
// mid-frame resync, LCD off/on and asynchronous reset during a frame.
module tb_ppu_fb_writer;
  localparam int W = 160;
  localparam int H = 144;
  localparam int N = W * H;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  palette = 8'hE4;
  logic        lcd_on = 1'b1;
  logic [14:0] addra;
  logic [1:0]  dina;
  logic        wea;
  logic        frame_done;
  logic        sync_err;
  logic        clearing;

  int tests_run    = 0;
  int tests_failed = 0;

  ppu_fb_writer_if px();

  ppu_fb_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(15)) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .px         (px),
    .palette    (palette),
    .lcd_on     (lcd_on),
    .addra      (addra),
    .dina       (dina),
    .wea        (wea),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .clearing   (clearing)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // Offer one beat, note px_ready before the edge, return 1 ns after the edge
  task automatic step(input logic v, input logic [1:0] c, input logic s, output logic rdy);
    px.px_valid = v;
    px.px_color = c;
    px.px_sof   = s;
    #1;
    rdy = px.px_ready;
    @(posedge clk_100mhz);
    #1;
  endtask

  // Run a full clear sweep; every cycle must write 0 at the next address
  task automatic run_clear(input string tag);
    int   nw = 0;
    int   bad = 0;
    int   rdy_hi = 0;
    int   cyc = 0;
    logic rdy;
    while (cyc < 24000) begin
      step(1'b0, 2'd0, 1'b0, rdy);
      cyc++;
      if (rdy) rdy_hi++;
      if (wea) begin
        if (addra != 15'(nw) || dina != 2'd0) bad++;
        nw++;
      end else begin
        bad++;
      end
      if (!clearing) break;
    end
    check({tag, "_writes"}, nw, N);
    check({tag, "_bad_writes"}, bad, 0);
    check({tag, "_ready_high"}, rdy_hi, 0);
    check({tag, "_finished"}, {31'd0, clearing}, 0);
  endtask

  // Stream contiguous pixels with palette 1B (shade = 3 - colour) up to pos == to
  task automatic advance(input int from, input int to, output int bad);
    logic       rdy;
    logic [1:0] c;
    bad = 0;
    for (int p = from; p < to; p++) begin
      c = 2'(p % 4);
      step(1'b1, c, 1'b0, rdy);
      if (!rdy || !wea || addra != 15'(p) || dina != 2'(3 - int'(c)) || sync_err || frame_done)
        bad++;
    end
  endtask

  initial begin
    logic       rdy;
    logic [1:0] c;
    logic [1:0] exp_shade;
    logic       v;
    int         bad, dones, done_last, pos;
    logic [14:0] a52;
    logic [1:0]  d52;

    px.px_valid = 1'b0;
    px.px_color = 2'd0;
    px.px_sof   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_100mhz);
    #1;
    check("rst_clearing", {31'd0, clearing}, 1);
    check("rst_wea", {31'd0, wea}, 0);
    check("rst_addra", {17'd0, addra}, 0);
    check("rst_ready", {31'd0, px.px_ready}, 0);
    check("rst_flags", {30'd0, frame_done, sync_err}, 0);
    rst = 1'b0;

    run_clear("clr0");
    check("wait_sof_ready", {31'd0, px.px_ready}, 1);

    // Full frame, palette E4 (identity), colour = (x+y)%4
    palette = 8'hE4;
    bad = 0; dones = 0; done_last = 0; a52 = '0; d52 = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        c = 2'((x + y) % 4);
        exp_shade = 2'((palette >> (2 * int'(c))) & 8'h3);
        step(1'b1, c, (x == 0 && y == 0), rdy);
        if (!rdy || !wea || addra != 15'(y * W + x) || dina != exp_shade || sync_err) bad++;
        if (frame_done) begin
          dones++;
          if (x == W - 1 && y == H - 1 && addra == 15'(N - 1)) done_last = 1;
        end
        if (x == 5 && y == 2) begin
          a52 = addra;
          d52 = dina;
        end
      end
    end
    check("frame_bad_writes", bad, 0);
    check("frame_done_count", dones, 1);
    check("frame_done_on_last", done_last, 1);
    check("px52_addr", {17'd0, a52}, 325);
    check("px52_shade", {30'd0, d52}, 3);
    step(1'b0, 2'd0, 1'b0, rdy);
    check("post_frame_wea", {31'd0, wea}, 0);
    check("post_frame_done_low", {31'd0, frame_done}, 0);

    // Pixels before the first SOF are discarded
    palette = 8'h1B;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'(i % 4), 1'b0, rdy);
      if (!rdy || wea) bad++;
    end
    check("pre_sof_discard", bad, 0);

    // Frame start then random valid gaps
    step(1'b1, 2'd0, 1'b1, rdy);
    check("sof_addr", {17'd0, addra}, 0);
    check("c0_shade_1b", {30'd0, dina}, 3);
    pos = 1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      step(v, c, 1'b0, rdy);
      if (v) begin
        if (!wea || addra != 15'(pos) || dina != 2'(3 - int'(c))) bad++;
        pos++;
      end else if (wea) begin
        bad++;
      end
      if (sync_err || frame_done) bad++;
    end
    check("gap_bad_writes", bad, 0);

    // Resync at x=37, y=10
    advance(pos, 10 * W + 37, bad);
    check("to_resync_bad", bad, 0);
    step(1'b1, 2'd2, 1'b1, rdy);
    check("resync_err", {31'd0, sync_err}, 1);
    check("resync_addr", {17'd0, addra}, 0);
    check("resync_shade", {30'd0, dina}, 1);
    step(1'b1, 2'd1, 1'b0, rdy);
    check("resync_next_addr", {17'd0, addra}, 1);
    check("resync_err_once", {31'd0, sync_err}, 0);

    // LCD off at (80,70)
    advance(2, 70 * W + 80, bad);
    check("to_drop_bad", bad, 0);
    lcd_on = 1'b0;
    step(1'b1, 2'd3, 1'b0, rdy);
    check("drop_ready", {31'd0, rdy}, 0);
    check("drop_no_write", {31'd0, wea}, 0);
    check("drop_clearing", {31'd0, clearing}, 1);
    run_clear("clr1");

    // OFF: pixel accepted but dropped; then WAIT_SOF and a new frame at 0
    lcd_on = 1'b1;
    step(1'b1, 2'd1, 1'b0, rdy);
    check("off_ready", {31'd0, rdy}, 1);
    check("off_discard", {31'd0, wea}, 0);
    step(1'b1, 2'd0, 1'b1, rdy);
    check("relit_sof_addr", {17'd0, addra}, 0);
    check("relit_sof_wea", {31'd0, wea}, 1);
    step(1'b1, 2'd1, 1'b0, rdy);
    check("relit_px1", {15'd0, addra, dina}, {15'd0, 15'd1, 2'd2});
    step(1'b1, 2'd2, 1'b0, rdy);
    check("relit_px2_wea", {31'd0, wea}, 1);

    // Asynchronous reset mid-line
    #2;
    rst = 1'b1;
    #1;
    check("arst_wea", {31'd0, wea}, 0);
    check("arst_addra", {17'd0, addra}, 0);
    check("arst_dina", {30'd0, dina}, 0);
    check("arst_clearing", {31'd0, clearing}, 1);
    check("arst_ready", {31'd0, px.px_ready}, 0);
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd3, 1'b0, rdy);
      if (rdy || !wea || !clearing || addra != 15'(i) || dina != 2'd0) bad++;
    end
    check("arst_clear_restart", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
